// File: rtl/sccb_config_tx_pkg.sv
// Shared constants and state encoding for the OV7670 SCCB configuration master.
package sccb_config_tx_pkg;

    localparam logic [7:0]  SCCB_ID_W = 8'h42;
    localparam logic [15:0] TBL_END   = 16'hFFFF;
    localparam logic [15:0] TBL_DELAY = 16'hFFF0;

    localparam int unsigned ACK_BIT   = 8;
    localparam int unsigned LAST_BYTE = 2;

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_IDLE,
        S_LOAD,
        S_START,
        S_SEND,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_e;

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational OV7670 register table: entry = {sub-address, data}, END / DELAY markers.
// TABLE_SEL 0 is the production set; 1 and 2 are short tables for simulation.
module ov7670_reg_rom
    import sccb_config_tx_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 64,
    parameter int unsigned TABLE_SEL = 0,
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [IW-1:0] idx,
    output logic [15:0]   entry
);

    logic [31:0] i;

    // Table lookup; unlisted indices read as END
    always_comb begin
        i     = 32'(idx);
        entry = TBL_END;
        if (TABLE_SEL == 1) begin
            case (i)
                32'd0:   entry = 16'h1280;
                32'd1:   entry = TBL_DELAY;
                32'd2:   entry = 16'h40D0;
                default: entry = TBL_END;
            endcase
        end else if (TABLE_SEL == 2) begin
            case (i)
                32'd0:   entry = 16'h1280;
                32'd1:   entry = 16'h40D0;
                default: entry = TBL_END;
            endcase
        end else begin
            case (i)
                32'd0:   entry = 16'h1280;   // COM7 soft reset
                32'd1:   entry = TBL_DELAY;  // settle after reset
                32'd2:   entry = 16'h1204;   // COM7 RGB output
                32'd3:   entry = 16'h8C02;   // RGB444 enable, xRGB
                32'd4:   entry = 16'h40D0;   // COM15 full range RGB
                32'd5:   entry = 16'h3A04;   // TSLB
                32'd6:   entry = 16'h0C04;   // COM3 scaling enable
                32'd7:   entry = 16'h3E1A;   // COM14 manual scaling, PCLK /4
                32'd8:   entry = 16'h703A;   // SCALING_XSC
                32'd9:   entry = 16'h7135;   // SCALING_YSC
                32'd10:  entry = 16'h7222;   // downsample by 4 (160x120)
                32'd11:  entry = 16'h73F2;   // DSP clock /4
                32'd12:  entry = 16'hA202;   // pixel clock delay
                32'd13:  entry = 16'h1100;   // CLKRC
                default: entry = TBL_END;
            endcase
        end
    end

endmodule

// File: rtl/sccb_config_tx.sv
// SCCB 3-phase write master that walks the OV7670 register table after reset or on start.
module sccb_config_tx
    import sccb_config_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SCCB_HZ     = 100_000,
    parameter int unsigned POWERUP_CYC = 50_000,
    parameter int unsigned DELAY_CYC   = 500_000,
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned TABLE_SEL   = 0,
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          sioc,
    output logic          siod_out,
    output logic          siod_oe,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] reg_idx
);

    localparam int unsigned QRAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned QDIV = (QRAW >= 1) ? QRAW : 1;
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned CMAX = (POWERUP_CYC > DELAY_CYC) ? POWERUP_CYC : DELAY_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned IDXW = IW + 1;

    state_e          state;
    logic [QW-1:0]   qcnt;
    logic            qt;
    logic [CW-1:0]   cnt;
    logic [1:0]      ph;
    logic [3:0]      bitn;
    logic [1:0]      byten;
    logic [23:0]     sr;
    logic [IDXW-1:0] idx;
    logic [15:0]     entry;
    logic            past_end;

    ov7670_reg_rom #(
        .NUM_REGS  (NUM_REGS),
        .TABLE_SEL (TABLE_SEL)
    ) u_rom (
        .idx   (idx[IW-1:0]),
        .entry (entry)
    );

    // Index one bit wider than reg_idx so stepping past the last entry reads as END
    assign past_end = (idx >= IDXW'(NUM_REGS));
    assign reg_idx  = idx[IW-1:0];
    assign qt       = (qcnt == QW'(QDIV - 1));

    // Free-running quarter-bit divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qcnt <= '0;
        end else if (qt) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + QW'(1);
        end
    end

    // Table walker and bus sequencer; bus pins only move on quarter ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_PWR_WAIT;
            sioc     <= 1'b1;
            siod_out <= 1'b1;
            siod_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            ph       <= '0;
            bitn     <= '0;
            byten    <= '0;
            sr       <= '0;
        end else begin
            case (state)
                S_PWR_WAIT: begin
                    busy <= 1'b1;
                    if (cnt == CW'(POWERUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (past_end || entry == TBL_END) begin
                        state <= S_DONE;
                    end else if (entry == TBL_DELAY) begin
                        cnt   <= '0;
                        state <= S_DELAY;
                    end else begin
                        sr    <= {SCCB_ID_W, entry};
                        byten <= '0;
                        bitn  <= '0;
                        ph    <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (qt) begin
                        if (ph == 2'd0) begin
                            siod_oe  <= 1'b1;
                            siod_out <= 1'b0;
                            ph       <= 2'd1;
                        end else begin
                            sioc  <= 1'b0;
                            ph    <= 2'd0;
                            state <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (qt) begin
                        ph <= ph + 2'd1;
                        case (ph)
                            2'd0: begin
                                if (bitn == 4'(ACK_BIT)) begin
                                    siod_oe <= 1'b0;
                                end else begin
                                    siod_oe  <= 1'b1;
                                    siod_out <= sr[23];
                                end
                            end
                            2'd1: sioc <= 1'b1;
                            2'd2: ;
                            default: begin
                                sioc <= 1'b0;
                                if (bitn == 4'(ACK_BIT)) begin
                                    bitn <= '0;
                                    if (byten == 2'(LAST_BYTE)) begin
                                        state <= S_STOP;
                                    end else begin
                                        byten <= byten + 2'd1;
                                    end
                                end else begin
                                    bitn <= bitn + 4'd1;
                                    sr   <= {sr[22:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (qt) begin
                        case (ph)
                            2'd0: begin
                                siod_oe  <= 1'b1;
                                siod_out <= 1'b0;
                                sioc     <= 1'b0;
                                ph       <= 2'd1;
                            end
                            2'd1: begin
                                sioc <= 1'b1;
                                ph   <= 2'd2;
                            end
                            default: begin
                                siod_out <= 1'b1;
                                ph       <= 2'd0;
                                state    <= S_GAP;
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (qt) begin
                        siod_oe <= 1'b0;
                        sioc    <= 1'b1;
                        ph      <= ph + 2'd1;
                        if (ph == 2'd3) begin
                            idx   <= idx + IDXW'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt == CW'(DELAY_CYC - 1)) begin
                        cnt   <= '0;
                        idx   <= idx + IDXW'(1);
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_config_tx.sv
// Bench for sccb_config_tx: bus decoder plus timing/contents model of the register table walk.
module tb_sccb_config_tx;

    localparam int POWERUP = 10;
    localparam int DLY     = 20;
    // quarters per write: START 2 + 27 bits x 4 + STOP 3 + GAP 4 (one clock each at QDIV=1)
    localparam int WR_Q    = 2 + 27 * 4 + 3 + 4;

    logic       clk;
    logic       rst_a, rst_b, start_a, start_b;
    logic       sioc_a, out_a, oe_a, busy_a, done_a;
    logic       sioc_b, out_b, oe_b, busy_b, done_b;
    logic [1:0] idx_a;
    logic [0:0] idx_b;

    sccb_config_tx #(
        .CLK_HZ(400), .SCCB_HZ(100), .POWERUP_CYC(POWERUP), .DELAY_CYC(DLY),
        .NUM_REGS(4), .TABLE_SEL(1)
    ) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .sioc(sioc_a), .siod_out(out_a),
        .siod_oe(oe_a), .busy(busy_a), .done(done_a), .reg_idx(idx_a)
    );

    sccb_config_tx #(
        .CLK_HZ(400), .SCCB_HZ(100), .POWERUP_CYC(POWERUP), .DELAY_CYC(DLY),
        .NUM_REGS(2), .TABLE_SEL(2)
    ) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .sioc(sioc_b), .siod_out(out_b),
        .siod_oe(oe_b), .busy(busy_b), .done(done_b), .reg_idx(idx_b)
    );

    typedef struct {
        logic [23:0] w;
        int          t;
    } wr_t;

    typedef struct {
        int   t;
        logic busy;
        logic done;
        int   idx;
        logic sioc;
        logic oe;
        logic siod;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          base_t[2];
    wr_t         got0[$];
    wr_t         got1[$];
    logic [15:0] mtbl[$];
    logic [23:0] exp_w[$];
    int          exp_t[$];
    int          exp_done;
    vec_t        vecs[15];

    // decoder state per channel
    logic        pc[2], pd[2], inf[2];
    int          nb[2], perr[2], fall_t[2];
    logic [26:0] sh[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // {busy, done, idx[7:0], sioc, siod_oe, siod on the wire}
    function automatic logic [12:0] obs(input int ch);
        if (ch == 0) return {busy_a, done_a, 8'(idx_a), sioc_a, oe_a, oe_a ? out_a : 1'b1};
        return {busy_b, done_b, 8'(idx_b), sioc_b, oe_b, oe_b ? out_b : 1'b1};
    endfunction

    // SCCB bus decoder: frames, bit capture, ACK release and SIOD-stable-while-SIOC-high rules
    task automatic dec(input int ch, input logic r, input logic c, input logic oe, input logic o);
        logic d, ev_stop;
        wr_t  x;
        d = oe ? o : 1'b1;
        ev_stop = 1'b0;
        if (!r) begin
            inf[ch] = 1'b0; nb[ch] = 0; pc[ch] = c; pd[ch] = d;
            return;
        end
        if (pc[ch] && c && pd[ch] && !d) begin
            if (inf[ch]) perr[ch]++;
            inf[ch] = 1'b1; nb[ch] = 0; fall_t[ch] = cyc;
        end else if (pc[ch] && c && !pd[ch] && d) begin
            ev_stop = 1'b1;
            if (!inf[ch] || nb[ch] != 27) perr[ch]++;
            else begin
                x.w = {sh[ch][26:19], sh[ch][17:10], sh[ch][8:1]};
                x.t = fall_t[ch];
                if (ch == 0) got0.push_back(x); else got1.push_back(x);
            end
            inf[ch] = 1'b0;
        end else if (pd[ch] != d && (pc[ch] || c)) begin
            perr[ch]++;
        end
        if (!pc[ch] && c) begin
            if (!inf[ch]) perr[ch]++;
            else if (nb[ch] < 27) begin
                if (((nb[ch] % 9) == 8) == oe) perr[ch]++;
                sh[ch] = {sh[ch][25:0], d};
                nb[ch]++;
            end else if (d) perr[ch]++;
        end
        if (pc[ch] && !c && !inf[ch]) perr[ch]++;
        if (!inf[ch] && !ev_stop && oe) perr[ch]++;
        pc[ch] = c;
        pd[ch] = d;
    endtask

    always @(negedge clk) begin
        dec(0, rst_a, sioc_a, oe_a, out_a);
        dec(1, rst_b, sioc_b, oe_b, out_b);
    end

    // Reference: walk mtbl from index 0 with LOAD at cycle load0 (relative to reset release)
    task automatic model(input int nregs, input int load0);
        int t;
        logic [15:0] e;
        t = load0;
        exp_w.delete();
        exp_t.delete();
        for (int i = 0; i <= nregs; i++) begin
            e = (i >= nregs) ? 16'hFFFF : mtbl[i];
            if (e == 16'hFFFF) begin
                exp_done = t + 1;
                return;
            end else if (e == 16'hFFF0) begin
                t = t + 1 + DLY;
            end else begin
                exp_w.push_back({8'h42, e});
                exp_t.push_back(t + 1);
                t = t + 1 + WR_Q;
            end
        end
    endtask

    task automatic wait_abs(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic hold_reset(input int ch);
        if (ch == 0) rst_a = 1'b0; else rst_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_dut(input int ch);
        if (ch == 0) begin got0.delete(); rst_a = 1'b1; end
        else begin got1.delete(); rst_b = 1'b1; end
        perr[ch]  = 0;
        base_t[ch] = cyc;
    endtask

    task automatic check_run(input int ch, input string tag);
        logic [12:0] o;
        int n;
        wr_t g;
        wait_abs(base_t[ch] + exp_done);
        o = obs(ch);
        chk({tag, " busy/done"}, 32'({o[12], o[11]}), 32'(2'b01));
        n = (ch == 0) ? got0.size() : got1.size();
        chk({tag, " writes"}, 32'(n), 32'(exp_w.size()));
        for (int i = 0; i < n && i < exp_w.size(); i++) begin
            if (ch == 0) g = got0[i]; else g = got1[i];
            chk($sformatf("%s word%0d", tag, i), 32'(g.w), 32'(exp_w[i]));
            chk($sformatf("%s fall%0d", tag, i), 32'(g.t - base_t[ch]), 32'(exp_t[i]));
        end
        chk({tag, " protocol"}, 32'(perr[ch]), 32'(0));
    endtask

    initial begin
        int ts, ta, s;
        vecs[0]  = '{0,   1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1,   1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{10,  1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{12,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{13,  1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{14,  1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{15,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{18,  1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{46,  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{124, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{129, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{140, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{149, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{268, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{269, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1};

        for (int c = 0; c < 2; c++) begin
            pc[c] = 1'b1; pd[c] = 1'b1; inf[c] = 1'b0; nb[c] = 0; perr[c] = 0;
            sh[c] = '0; fall_t[c] = 0; base_t[c] = 0;
        end
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset a", 32'(obs(0)), 32'({1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1}));
        chk("reset b", 32'(obs(1)), 32'({1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1}));

        // power-up, table walk with DELAY, bit timing
        mtbl = {16'h1280, 16'hFFF0, 16'h40D0, 16'hFFFF};
        model(4, POWERUP + 1);
        release_dut(0);
        for (int i = 0; i < 15; i++) begin
            wait_abs(base_t[0] + vecs[i].t);
            chk($sformatf("vec t=%0d", vecs[i].t), 32'(obs(0)),
                32'({vecs[i].busy, vecs[i].done, 8'(vecs[i].idx), vecs[i].sioc, vecs[i].oe, vecs[i].siod}));
        end
        check_run(0, "run1");

        // start while busy is ignored
        hold_reset(0);
        model(4, POWERUP + 1);
        release_dut(0);
        ts = int'($urandom_range(1, exp_done - 2));
        wait_abs(base_t[0] + ts);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_run(0, "busy_start");

        // start after done replays from index 0
        repeat (int'($urandom_range(1, 5))) @(negedge clk);
        got0.delete();
        s = cyc - base_t[0];
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("restart busy/done/idx", 32'(obs(0) >> 3), 32'({1'b1, 1'b0, 8'd0}));
        model(4, s + 2);
        check_run(0, "replay");

        // reset mid-frame: bus idle immediately, full restart after release
        for (int it = 0; it < 4; it++) begin
            hold_reset(0);
            model(4, POWERUP + 1);
            release_dut(0);
            ta = (it == 0) ? exp_t[0] + 54 : int'($urandom_range(2, exp_done - 1));
            wait_abs(base_t[0] + ta);
            if (it == 0) chk("pre-abort sioc/oe", 32'({sioc_a, oe_a}), 32'(2'b01));
            rst_a = 1'b0;
            #1;
            chk($sformatf("abort%0d idle", it), 32'(obs(0) >> 1),
                32'({1'b0, 1'b0, 8'd0, 1'b1, 1'b0}));
            repeat (2) @(negedge clk);
            release_dut(0);
            check_run(0, $sformatf("after_abort%0d", it));
        end

        // table without END: index past NUM_REGS-1 terminates
        mtbl = {16'h1280, 16'h40D0};
        model(2, POWERUP + 1);
        release_dut(1);
        check_run(1, "short");
        repeat (150) @(negedge clk);
        chk("short no 3rd write", 32'(got1.size()), 32'(2));
        chk("short still done", 32'({busy_b, done_b}), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
